// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral that decodes framed write/read transactions into a register bank.
// Optional macro SPI_READBACK_EN adds cipo readback of the addressed register in read frames.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic                       cipo,
  output logic                       cipo_oe
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_prev;
  logic                   ncs_prev;

  // ncs synchroniser resets high so reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      ncs_prev  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_len_ok;
  logic              addr_ok;

  assign frame_rw     = shreg[FRAME_W-1];
  assign frame_addr   = shreg[FRAME_W-2 -: ADDR_W];
  assign frame_data   = shreg[DATA_W-1:0];
  assign frame_len_ok = (bit_cnt == CNT_W'(FRAME_W));
  assign addr_ok      = ({1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      regs_flat <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_W-2:0], copi_s};
            // Saturate one past a full frame so over-long frames stay detectable.
            if (bit_cnt != CNT_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (!frame_len_ok) begin
            frame_err <= 1'b1;
          end else if (frame_rw) begin
            if (addr_ok) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (frame_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= frame_data;
              end
              wr_addr   <= frame_addr;
              wr_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
`ifdef SPI_READBACK_EN
          else if (!addr_ok) begin
            frame_err <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [ADDR_W:0]   hdr_next;
  logic              rd_load;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_sr;

  assign sclk_fall = ~sclk_s & sclk_prev;
  assign hdr_next  = {shreg[ADDR_W-1:0], copi_s};
  // Load on the rising edge that completes the R/W + address header of a read.
  assign rd_load   = (state == SHIFT) && !ncs_rise && sclk_rise &&
                     (bit_cnt == CNT_W'(ADDR_W)) && !hdr_next[ADDR_W];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr  <= '0;
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else begin
      cipo_oe <= ~ncs_s;
      if (ncs_s) begin
        out_sr <= '0;
        cipo   <= 1'b0;
      end else if (rd_load) begin
        out_sr <= rd_data;
      end else if (sclk_fall) begin
        cipo   <= out_sr[DATA_W-1];
        out_sr <= {out_sr[DATA_W-2:0], 1'b0};
      end
    end
  end
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule
